// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32 instruction encoder: field check/pack stage feeding an output FIFO
module instr_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rs3_i,
  input  logic [31:0] imm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] instr_o,
  output logic        err_o,
  output logic [15:0] instr_cnt_o,
  output logic [7:0]  err_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] occ;
  logic          ready_en;
  logic          s1_valid, s1_err;
  logic [31:0]   s1_word;
  logic [31:0]   packed_word;
  logic          bad;
  logic          accept, push, pop;

  always_comb begin
    packed_word = 32'h0;
    bad = 1'b0;
    case (fmt_i)
      3'd0: packed_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      3'd1: begin
        packed_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        bad = imm_i[31:11] != {21{imm_i[11]}};
      end
      3'd2: begin
        packed_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        bad = imm_i[31:11] != {21{imm_i[11]}};
      end
      3'd3: begin
        packed_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
        bad = (imm_i[31:12] != {20{imm_i[12]}}) || imm_i[0];
      end
      3'd4: begin
        packed_word = {imm_i[31:12], rd_i, opcode_i};
        bad = imm_i[11:0] != 12'h0;
      end
      3'd5: begin
        packed_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        bad = (imm_i[31:20] != {12{imm_i[20]}}) || imm_i[0];
      end
      3'd6: packed_word = {rs3_i, funct7_i[1:0], rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      default: bad = 1'b1;
    endcase
    if (opcode_i[1:0] != 2'b11) bad = 1'b1;
  end

  // Stage-1 slot is reserved against FIFO space so a checked word can always be pushed.
  assign occ         = {1'b0, count} + {{(AW+1){1'b0}}, s1_valid};
  assign in_ready_o  = ready_en && (occ < DEPTH_W);
  assign accept      = in_valid_i && in_ready_o;
  assign push        = s1_valid && !s1_err;
  assign out_valid_o = count != '0;
  assign pop         = out_valid_o && out_ready_i;
  assign instr_o     = out_valid_o ? mem[rd_ptr] : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_en    <= 1'b0;
      s1_valid    <= 1'b0;
      s1_err      <= 1'b0;
      s1_word     <= 32'h0;
      err_o       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      instr_cnt_o <= 16'h0;
      err_cnt_o   <= 8'h0;
    end else begin
      ready_en <= 1'b1;
      s1_valid <= accept;
      err_o    <= accept && bad;
      if (accept) begin
        s1_word <= packed_word;
        s1_err  <= bad;
      end
      if (accept && bad && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'h1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        instr_cnt_o <= instr_cnt_o + 16'h1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s1_word;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed scoreboard bench for instr_encoder
module tb_instr_encoder;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [31:0] imm;
  } bundle_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_i, in_ready_o;
  logic [2:0]  fmt_i;
  logic [6:0]  opcode_i, funct7_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i, rs1_i, rs2_i, rs3_i;
  logic [31:0] imm_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] instr_o;
  logic        err_o;
  logic [15:0] instr_cnt_o;
  logic [7:0]  err_cnt_o;

  instr_encoder #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .fmt_i(fmt_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i), .imm_i(imm_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .instr_o(instr_o),
    .err_o(err_o), .instr_cnt_o(instr_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          exp_err = 0;
  int          err_pulses = 0;
  logic [31:0] exp_q[$];
  bundle_t     vec[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t mk(input logic [2:0] fmt, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rs3,
                                 input logic [31:0] imm);
    bundle_t b;
    b.fmt = fmt; b.op = op; b.f3 = f3; b.f7 = f7; b.rd = rd;
    b.rs1 = rs1; b.rs2 = rs2; b.rs3 = rs3; b.imm = imm;
    return b;
  endfunction

  function automatic logic legal(input bundle_t b);
    int s;
    s = $signed(b.imm);
    if (b.fmt == 3'd7 || b.op[1:0] != 2'b11) return 1'b0;
    case (b.fmt)
      3'd1, 3'd2: return (s >= -2048) && (s <= 2047);
      3'd3:       return (s >= -4096) && (s <= 4095) && !b.imm[0];
      3'd4:       return b.imm[11:0] == 12'h0;
      3'd5:       return (s >= -(1 << 20)) && (s < (1 << 20)) && !b.imm[0];
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] model(input bundle_t b);
    logic [31:0] w;
    w = 32'h0;
    w[6:0] = b.op;
    case (b.fmt)
      3'd0: begin w[31:25] = b.f7; w[24:20] = b.rs2; w[19:15] = b.rs1; w[14:12] = b.f3; w[11:7] = b.rd; end
      3'd1: begin w[31:20] = b.imm[11:0]; w[19:15] = b.rs1; w[14:12] = b.f3; w[11:7] = b.rd; end
      3'd2: begin w[31:25] = b.imm[11:5]; w[24:20] = b.rs2; w[19:15] = b.rs1; w[14:12] = b.f3; w[11:7] = b.imm[4:0]; end
      3'd3: begin
        w[31] = b.imm[12]; w[30:25] = b.imm[10:5]; w[24:20] = b.rs2; w[19:15] = b.rs1;
        w[14:12] = b.f3; w[11:8] = b.imm[4:1]; w[7] = b.imm[11];
      end
      3'd4: begin w[31:12] = b.imm[31:12]; w[11:7] = b.rd; end
      3'd5: begin
        w[31] = b.imm[20]; w[30:21] = b.imm[10:1]; w[20] = b.imm[11];
        w[19:12] = b.imm[19:12]; w[11:7] = b.rd;
      end
      default: begin
        w[31:27] = b.rs3; w[26:25] = b.f7[1:0]; w[24:20] = b.rs2;
        w[19:15] = b.rs1; w[14:12] = b.f3; w[11:7] = b.rd;
      end
    endcase
    return w;
  endfunction

  task automatic drive(input bundle_t b);
    fmt_i = b.fmt; opcode_i = b.op; funct3_i = b.f3; funct7_i = b.f7;
    rd_i = b.rd; rs1_i = b.rs1; rs2_i = b.rs2; rs3_i = b.rs3; imm_i = b.imm;
  endtask

  // Called at a negedge: scores any pop the coming edge will perform, then advances one cycle.
  task automatic tick();
    logic [31:0] e;
    if (out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) check("spurious_word", {31'h0, out_valid_o}, 32'h0);
      else begin
        e = exp_q.pop_front();
        check("instr_o", instr_o, e);
        pops++;
      end
    end
    if (err_o) err_pulses++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input bundle_t b, input logic use_const, input logic [31:0] cw);
    logic acc, done;
    done = 1'b0;
    drive(b);
    in_valid_i = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      acc = in_ready_o;
      tick();
      if (acc) done = 1'b1;
    end
    in_valid_i = 1'b0;
    check("accepted", {31'h0, done}, 32'h1);
    if (!legal(b)) exp_err++;
    else exp_q.push_back(use_const ? cw : model(b));
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
    tick();
    tick();
    check("drain_left", exp_q.size(), 32'h0);
    check("drain_out_valid", {31'h0, out_valid_o}, 32'h0);
    check("instr_cnt", {16'h0, instr_cnt_o}, pops);
  endtask

  initial begin
    bundle_t b;
    logic    acc;
    int      idx;
    int      base;

    reset = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check("rst_in_ready", {31'h0, in_ready_o}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid_o}, 32'h0);
    check("rst_instr", instr_o, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    check("rst_instr_cnt", {16'h0, instr_cnt_o}, 32'h0);
    check("rst_err_cnt", {24'h0, err_cnt_o}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_before_edge", {31'h0, in_ready_o}, 32'h0);
    @(negedge clk);
    check("ready_after_edge", {31'h0, in_ready_o}, 32'h1);

    // ADD x3,x1,x2 with explicit two-edge latency
    drive(mk(0, 7'h33, 0, 0, 3, 1, 2, 0, 0));
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check("add_lat1_valid", {31'h0, out_valid_o}, 32'h0);
    tick();
    check("add_lat2_valid", {31'h0, out_valid_o}, 32'h1);
    check("add_word", instr_o, 32'h002081B3);
    exp_q.push_back(32'h002081B3);
    drain();

    send(mk(1, 7'h13, 0, 0, 1, 0, 0, 0, 32'hFFFFFFFF), 1'b1, 32'hFFF00093);
    send(mk(5, 7'h6F, 0, 0, 1, 0, 0, 0, 32'h00000800), 1'b1, 32'h001000EF);
    drain();

    // Misaligned branch is rejected; the following bundle must still encode
    send(mk(3, 7'h63, 0, 0, 0, 1, 2, 0, 32'd3), 1'b0, 32'h0);
    tick();
    tick();
    check("b_err_pulses", err_pulses, 32'd1);
    check("b_err_cnt", {24'h0, err_cnt_o}, 32'd1);
    check("b_no_word", {31'h0, out_valid_o}, 32'h0);
    send(mk(0, 7'h33, 0, 7'h20, 5, 6, 7, 0, 0), 1'b0, 32'h0);
    drain();

    vec.push_back(mk(2, 7'h23, 2, 0, 0, 2, 5, 0, -32'sd4));
    vec.push_back(mk(3, 7'h63, 1, 0, 0, 3, 4, 0, -32'sd4096));
    vec.push_back(mk(3, 7'h63, 1, 0, 0, 3, 4, 0, 32'd4094));
    vec.push_back(mk(3, 7'h63, 1, 0, 0, 3, 4, 0, 32'd4096));
    vec.push_back(mk(4, 7'h37, 0, 0, 5, 0, 0, 0, 32'h12345000));
    vec.push_back(mk(4, 7'h37, 0, 0, 5, 0, 0, 0, 32'h12345001));
    vec.push_back(mk(6, 7'h43, 3, 7'h02, 9, 10, 11, 7, 0));
    vec.push_back(mk(1, 7'h13, 0, 0, 2, 3, 0, 0, 32'd2047));
    vec.push_back(mk(1, 7'h13, 0, 0, 2, 3, 0, 0, 32'd2048));
    vec.push_back(mk(1, 7'h13, 0, 0, 2, 3, 0, 0, -32'sd2048));
    vec.push_back(mk(2, 7'h23, 0, 0, 0, 3, 4, 0, -32'sd2049));
    vec.push_back(mk(5, 7'h6F, 0, 0, 1, 0, 0, 0, 32'hFFF00000));
    vec.push_back(mk(5, 7'h6F, 0, 0, 1, 0, 0, 0, 32'h00100000));
    vec.push_back(mk(5, 7'h6F, 0, 0, 1, 0, 0, 0, 32'd3));
    vec.push_back(mk(7, 7'h33, 0, 0, 1, 1, 1, 0, 0));
    vec.push_back(mk(0, 7'h30, 0, 0, 1, 1, 1, 0, 0));
    out_ready_i = 1'b1;
    foreach (vec[i]) send(vec[i], 1'b0, 32'h0);
    drain();
    check("vec_err_cnt", {24'h0, err_cnt_o}, exp_err);
    check("vec_err_pulses", err_pulses, exp_err);

    // Backpressure: six offers into a depth-4 FIFO with the consumer stalled
    out_ready_i = 1'b0;
    base = pops;
    idx = 0;
    vec.delete();
    for (int i = 0; i < 6; i++) vec.push_back(mk(1, 7'h13, 0, 0, 5'(i + 10), 1, 0, 0, 32'(i * 8)));
    for (int n = 0; n < 10; n++) begin
      drive(vec[idx]);
      in_valid_i = 1'b1;
      acc = in_ready_o;
      tick();
      if (acc) begin
        exp_q.push_back(model(vec[idx]));
        idx++;
      end
    end
    in_valid_i = 1'b0;
    check("bp_accepted", idx, 32'd4);
    check("bp_ready_low", {31'h0, in_ready_o}, 32'h0);
    drain();
    check("bp_drained", {16'h0, instr_cnt_o}, base + 4);
    send(vec[4], 1'b0, 32'h0);
    send(vec[5], 1'b0, 32'h0);
    drain();

    // Asynchronous reset with three words queued
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(0, 7'h33, 0, 0, 5'(i + 1), 2, 3, 0, 0), 1'b0, 32'h0);
    tick();
    tick();
    check("pre_rst_valid", {31'h0, out_valid_o}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", {31'h0, out_valid_o}, 32'h0);
    check("arst_instr", instr_o, 32'h0);
    check("arst_in_ready", {31'h0, in_ready_o}, 32'h0);
    check("arst_instr_cnt", {16'h0, instr_cnt_o}, 32'h0);
    check("arst_err_cnt", {24'h0, err_cnt_o}, 32'h0);
    exp_q.delete();
    pops = 0;
    exp_err = 0;
    err_pulses = 0;
    @(negedge clk);
    reset = 1'b1;
    out_ready_i = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    check("post_rst_empty", {31'h0, out_valid_o}, 32'h0);
    send(mk(0, 7'h33, 0, 0, 3, 1, 2, 0, 0), 1'b1, 32'h002081B3);
    drain();
    check("post_rst_cnt", {16'h0, instr_cnt_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
